pulse_reg_bank: RTL and testbench

Multi-channel, double-buffered successor to the single-channel pulse parameter register. Per channel, a staging register set (env_word, phase, freq, amp, cfg) is written field-by-field from the pulse command word or from a proc register. On cstrobe_in, the selected channel's staging set is committed atomically to its active set, which drives that channel's element/DAC pipeline. Sits between the proc instruction decoder and N_CHANNELS pulse outputs; lets one proc core retime several channels without glitching active pulses.

---
 rtl/pulse_reg_bank_pkg.sv | 58 +++++
 rtl/pulse_reg_chan.sv | 72 +++++++
 rtl/pulse_reg_bank.sv | 84 ++++++++
 tb/tb_pulse_reg_bank.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pulse_reg_bank_pkg.sv
// Shared field widths, command-word layout and merge helper for pulse_reg_bank.
// Field widths here fix the struct layout; the top-level width parameters must match them.
package pulse_reg_bank_pkg;

    localparam int DATA_W  = 32;
    localparam int ENV_W   = 24;
    localparam int PHASE_W = 17;
    localparam int FREQ_W  = 9;
    localparam int AMP_W   = 16;
    localparam int CFG_W   = 4;
    localparam int CMD_W   = ENV_W + PHASE_W + FREQ_W + AMP_W + CFG_W + 9;

    // Command word, LSB upward: cfg | cfg_wen | amp | amp_ctrl | freq | freq_ctrl | phase | phase_ctrl | env | env_ctrl
    localparam int CFG_LSB        = 0;
    localparam int CFG_WEN        = CFG_LSB + CFG_W;
    localparam int AMP_LSB        = CFG_WEN + 1;
    localparam int AMP_CTRL_LSB   = AMP_LSB + AMP_W;
    localparam int AMP_CTRL_MSB   = AMP_CTRL_LSB + 1;
    localparam int FREQ_LSB       = AMP_CTRL_MSB + 1;
    localparam int FREQ_CTRL_LSB  = FREQ_LSB + FREQ_W;
    localparam int FREQ_CTRL_MSB  = FREQ_CTRL_LSB + 1;
    localparam int PHASE_LSB      = FREQ_CTRL_MSB + 1;
    localparam int PHASE_CTRL_LSB = PHASE_LSB + PHASE_W;
    localparam int PHASE_CTRL_MSB = PHASE_CTRL_LSB + 1;
    localparam int ENV_LSB        = PHASE_CTRL_MSB + 1;
    localparam int ENV_CTRL_LSB   = ENV_LSB + ENV_W;
    localparam int ENV_CTRL_MSB   = ENV_CTRL_LSB + 1;

    typedef struct packed {
        logic [ENV_W-1:0]   env;
        logic [PHASE_W-1:0] phase;
        logic [FREQ_W-1:0]  freq;
        logic [AMP_W-1:0]   amp;
        logic [CFG_W-1:0]   cfg;
    } pulse_params_t;

    // Merge the enabled fields of a command over an existing parameter set.
    function automatic pulse_params_t decode_cmd(
        input logic [CMD_W-1:0]  cmd,
        input logic [DATA_W-1:0] reg_in,
        input pulse_params_t     old
    );
        pulse_params_t p;
        p = old;
        if (cmd[ENV_CTRL_MSB])
            p.env = cmd[ENV_CTRL_LSB] ? reg_in[ENV_W-1:0] : cmd[ENV_LSB +: ENV_W];
        if (cmd[PHASE_CTRL_MSB])
            p.phase = cmd[PHASE_CTRL_LSB] ? reg_in[PHASE_W-1:0] : cmd[PHASE_LSB +: PHASE_W];
        if (cmd[FREQ_CTRL_MSB])
            p.freq = cmd[FREQ_CTRL_LSB] ? reg_in[FREQ_W-1:0] : cmd[FREQ_LSB +: FREQ_W];
        if (cmd[AMP_CTRL_MSB])
            p.amp = cmd[AMP_CTRL_LSB] ? reg_in[AMP_W-1:0] : cmd[AMP_LSB +: AMP_W];
        if (cmd[CFG_WEN])
            p.cfg = cmd[CFG_LSB +: CFG_W];
        return p;
    endfunction

endpackage

// File: rtl/pulse_reg_chan.sv
// One channel of the bank: staging set, active set, dirty flag and commit strobe.
// Optional commit statistics under PULSE_REG_BANK_STATS_EN.
module pulse_reg_chan
    import pulse_reg_bank_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CMD_W-1:0]    i_cmd,
    input  logic [DATA_W-1:0]   i_reg,
    input  logic                i_wr,
    input  logic                i_commit,
    output pulse_params_t       o_active,
    output logic                o_cstrobe,
`ifdef PULSE_REG_BANK_STATS_EN
    output logic [15:0]         o_commit_cnt,
    output logic                o_stale,
`endif
    output logic                o_dirty
);

    pulse_params_t r_stage;
    pulse_params_t r_active;
    pulse_params_t w_view;
    logic          r_cstrobe;
    logic          r_dirty;

    // Bypassed staging view: a same-cycle write is merged before commit.
    assign w_view = i_wr ? decode_cmd(i_cmd, i_reg, r_stage) : r_stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage   <= '0;
            r_active  <= '0;
            r_cstrobe <= 1'b0;
            r_dirty   <= 1'b0;
        end else begin
            r_cstrobe <= i_commit;
            if (i_wr)
                r_stage <= w_view;
            if (i_commit) begin
                r_active <= w_view;
                r_dirty  <= 1'b0;
            end else if (i_wr) begin
                r_dirty  <= 1'b1;
            end
        end
    end

`ifdef PULSE_REG_BANK_STATS_EN
    logic [15:0] r_commit_cnt;
    logic        r_stale;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_commit_cnt <= '0;
            r_stale      <= 1'b0;
        end else begin
            r_stale <= i_commit && !r_dirty && !i_wr;
            if (i_commit)
                r_commit_cnt <= r_commit_cnt + 16'd1;
        end
    end

    assign o_commit_cnt = r_commit_cnt;
    assign o_stale      = r_stale;
`endif

    assign o_active  = r_active;
    assign o_cstrobe = r_cstrobe;
    assign o_dirty   = r_dirty;

endmodule

// File: rtl/pulse_reg_bank.sv
// Multi-channel double-buffered pulse parameter bank: channel decode, cmd_err, output packing.
// Define PULSE_REG_BANK_STATS_EN to add commit_cnt / stale_commit outputs.
module pulse_reg_bank
    import pulse_reg_bank_pkg::*;
#(
    parameter int N_CHANNELS     = 4,
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ENV_WORD_WIDTH = ENV_W,
    parameter int PHASE_WIDTH    = PHASE_W,
    parameter int FREQ_WIDTH     = FREQ_W,
    parameter int AMP_WIDTH      = AMP_W,
    parameter int CFG_WIDTH      = CFG_W,
    localparam int CHAN_W          = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int PULSE_CMD_WIDTH = ENV_WORD_WIDTH + PHASE_WIDTH + FREQ_WIDTH
                                   + AMP_WIDTH + CFG_WIDTH + 9
)(
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [CHAN_W-1:0]                    chan_sel,
    input  logic [PULSE_CMD_WIDTH-1:0]           pulse_cmd_in,
    input  logic [DATA_WIDTH-1:0]                reg_in,
    input  logic                                 pulse_write_en,
    input  logic                                 cstrobe_in,
    output logic [N_CHANNELS*ENV_WORD_WIDTH-1:0] env_word_out,
    output logic [N_CHANNELS*PHASE_WIDTH-1:0]    phase_out,
    output logic [N_CHANNELS*FREQ_WIDTH-1:0]     freq_out,
    output logic [N_CHANNELS*AMP_WIDTH-1:0]      amp_out,
    output logic [N_CHANNELS*CFG_WIDTH-1:0]      cfg_out,
    output logic [N_CHANNELS-1:0]                cstrobe_out,
    output logic [N_CHANNELS-1:0]                dirty,
`ifdef PULSE_REG_BANK_STATS_EN
    output logic [N_CHANNELS*16-1:0]             commit_cnt,
    output logic [N_CHANNELS-1:0]                stale_commit,
`endif
    output logic                                 cmd_err
);

    localparam logic [CHAN_W:0] NCH = (CHAN_W+1)'(N_CHANNELS);

    logic          w_chan_ok;
    logic          r_cmd_err;
    pulse_params_t w_active [N_CHANNELS];

    // Out-of-range selects only exist when N_CHANNELS is not a power of two.
    assign w_chan_ok = (N_CHANNELS == 1) || ({1'b0, chan_sel} < NCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cmd_err <= 1'b0;
        else
            r_cmd_err <= !w_chan_ok && (pulse_write_en || cstrobe_in);
    end

    assign cmd_err = r_cmd_err;

    for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
        logic w_sel;

        assign w_sel = w_chan_ok && ((N_CHANNELS == 1) || (chan_sel == CHAN_W'(i)));

        pulse_reg_chan u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_cmd        (pulse_cmd_in),
            .i_reg        (reg_in),
            .i_wr         (w_sel && pulse_write_en),
            .i_commit     (w_sel && cstrobe_in),
            .o_active     (w_active[i]),
            .o_cstrobe    (cstrobe_out[i]),
`ifdef PULSE_REG_BANK_STATS_EN
            .o_commit_cnt (commit_cnt[i*16 +: 16]),
            .o_stale      (stale_commit[i]),
`endif
            .o_dirty      (dirty[i])
        );

        assign env_word_out[i*ENV_WORD_WIDTH +: ENV_WORD_WIDTH] = w_active[i].env;
        assign phase_out[i*PHASE_WIDTH +: PHASE_WIDTH]          = w_active[i].phase;
        assign freq_out[i*FREQ_WIDTH +: FREQ_WIDTH]             = w_active[i].freq;
        assign amp_out[i*AMP_WIDTH +: AMP_WIDTH]                = w_active[i].amp;
        assign cfg_out[i*CFG_WIDTH +: CFG_WIDTH]                = w_active[i].cfg;
    end

endmodule

// File: tb/tb_pulse_reg_bank.sv
// Directed bench for pulse_reg_bank: a 4-channel instance for the main function and a
// 3-channel instance for the out-of-range select case.
module tb_pulse_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [78:0] cmd;
    logic [31:0] reg_in;

    logic [1:0]  sel4, sel3;
    logic        we4, cs4, we3, cs3;

    logic [95:0] env4;   logic [67:0] ph4;  logic [35:0] fr4;  logic [63:0] amp4;
    logic [15:0] cfg4;   logic [3:0]  cso4; logic [3:0]  dty4; logic err4;
    logic [71:0] env3;   logic [50:0] ph3;  logic [26:0] fr3;  logic [47:0] amp3;
    logic [11:0] cfg3;   logic [2:0]  cso3; logic [2:0]  dty3; logic err3;
`ifdef PULSE_REG_BANK_STATS_EN
    logic [63:0] cnt4; logic [3:0] stale4;
    logic [47:0] cnt3; logic [2:0] stale3;
`endif

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    pulse_reg_bank #(.N_CHANNELS(4)) u4 (
        .clk(clk), .rst_n(rst_n), .chan_sel(sel4), .pulse_cmd_in(cmd), .reg_in(reg_in),
        .pulse_write_en(we4), .cstrobe_in(cs4),
        .env_word_out(env4), .phase_out(ph4), .freq_out(fr4), .amp_out(amp4), .cfg_out(cfg4),
        .cstrobe_out(cso4), .dirty(dty4),
`ifdef PULSE_REG_BANK_STATS_EN
        .commit_cnt(cnt4), .stale_commit(stale4),
`endif
        .cmd_err(err4)
    );

    pulse_reg_bank #(.N_CHANNELS(3)) u3 (
        .clk(clk), .rst_n(rst_n), .chan_sel(sel3), .pulse_cmd_in(cmd), .reg_in(reg_in),
        .pulse_write_en(we3), .cstrobe_in(cs3),
        .env_word_out(env3), .phase_out(ph3), .freq_out(fr3), .amp_out(amp3), .cfg_out(cfg3),
        .cstrobe_out(cso3), .dirty(dty3),
`ifdef PULSE_REG_BANK_STATS_EN
        .commit_cnt(cnt3), .stale_commit(stale3),
`endif
        .cmd_err(err3)
    );

    function automatic logic [78:0] mk_cmd(
        input logic [1:0] ec, input logic [23:0] env,
        input logic [1:0] pc, input logic [16:0] ph,
        input logic [1:0] fc, input logic [8:0]  fr,
        input logic [1:0] ac, input logic [15:0] am,
        input logic       cw, input logic [3:0]  cf
    );
        return {ec, env, pc, ph, fc, fr, ac, am, cw, cf};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle4();
        we4 = 1'b0; cs4 = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cmd = '0; reg_in = '0;
        sel4 = '0; sel3 = '0; we4 = 0; cs4 = 0; we3 = 0; cs3 = 0;
        tick(2);
        rst_n = 1'b1;
        tick(10);

        // Reset / idle state
        chk("rst_env",   env4, 0);
        chk("rst_phase", ph4,  0);
        chk("rst_freq",  fr4,  0);
        chk("rst_amp",   amp4, 0);
        chk("rst_cfg",   cfg4, 0);
        chk("rst_cso",   cso4, 0);
        chk("rst_dirty", dty4, 0);
        chk("rst_err",   err4, 0);

        // ch2 amp from command, strobe on the following cycle
        sel4 = 2'd2; cmd = mk_cmd(0, 0, 0, 0, 0, 0, 2'b10, 16'h1234, 0, 0); we4 = 1;
        tick(); idle4();
        chk("ch2_dirty_set", dty4, 4'b0100);
        chk("ch2_amp_held",  amp4, 0);
        chk("ch2_cso_idle",  cso4, 0);
        cs4 = 1;
        tick(); idle4();
        chk("ch2_cso",        cso4, 4'b0100);
        chk("ch2_amp",        amp4, 64'h0000_1234_0000_0000);
        chk("ch2_dirty_clr",  dty4, 0);
        tick();
        chk("ch2_cso_1cyc",   cso4, 0);
        chk("ch2_amp_stable", amp4, 64'h0000_1234_0000_0000);

        // ch1 phase from reg_in with same-cycle strobe: bypass and truncation
        sel4 = 2'd1; cmd = mk_cmd(0, 0, 2'b11, 17'h0, 0, 0, 0, 0, 0, 0);
        reg_in = 32'hFFFF_FFFF; we4 = 1; cs4 = 1;
        tick(); idle4();
        chk("ch1_phase", ph4[17 +: 17], 17'h1FFFF);
        chk("ch1_phase_others", {ph4[34 +: 34], ph4[0 +: 17]}, 0);
        chk("ch1_cso",   cso4, 4'b0010);
        chk("ch1_dirty", dty4, 0);
        chk("ch1_env_untouched", env4, 0);

        // ch0 env write without strobe, later commit
        sel4 = 2'd0; cmd = mk_cmd(2'b10, 24'hABCDEF, 0, 0, 0, 0, 0, 0, 0, 0); we4 = 1;
        tick(); idle4();
        chk("ch0_env_held",  env4, 0);
        chk("ch0_dirty_set", dty4, 4'b0001);
        tick(3);
        chk("ch0_env_still", env4, 0);
        cs4 = 1;
        tick(); idle4();
        chk("ch0_env",       env4, 96'hABCDEF);
        chk("ch0_cso",       cso4, 4'b0001);
        chk("ch0_dirty_clr", dty4, 0);

        // ch3 freq from reg, cfg from cmd, amp ctrl not enabled
        sel4 = 2'd3; reg_in = 32'hFFFF_F1A5;
        cmd = mk_cmd(0, 24'h111111, 2'b01, 17'h1, 2'b11, 9'h0, 2'b00, 16'hFFFF, 1'b1, 4'hA);
        we4 = 1;
        tick(); idle4();
        cs4 = 1;
        tick(); idle4();
        chk("ch3_freq",  fr4, {9'h1A5, 27'h0});
        chk("ch3_cfg",   cfg4, 16'hA000);
        chk("ch3_amp",   amp4, 64'h0000_1234_0000_0000);
        chk("ch3_phase", ph4[51 +: 17], 0);
        chk("ch3_cso",   cso4, 4'b1000);

        // Back-to-back strobes on different channels
        sel4 = 2'd0; cs4 = 1;
        tick();
        chk("b2b_first", cso4, 4'b0001);
        sel4 = 2'd1;
        tick(); idle4();
        chk("b2b_second", cso4, 4'b0010);
        chk("b2b_env_kept", env4, 96'hABCDEF);

        // Reset one cycle after a ch3 strobe
        sel4 = 2'd3; cs4 = 1;
        tick(); idle4();
        chk("mid_cso_before", cso4, 4'b1000);
        rst_n = 1'b0;
        #1;
        chk("mid_cso_cleared", cso4, 0);
        chk("mid_freq_cleared", fr4, 0);
        sel4 = 2'd3; cs4 = 1;
        tick();
        idle4();
        rst_n = 1'b1;
        tick(3);
        chk("post_rst_cso",  cso4, 0);
        chk("post_rst_ch3",  {fr4[27 +: 9], cfg4[12 +: 4]}, 0);
        chk("post_rst_env",  env4, 0);
        chk("post_rst_dirty", dty4, 0);

        // 3-channel instance: seed ch0, then an out-of-range select
        sel3 = 2'd0; cmd = mk_cmd(0, 0, 0, 0, 0, 0, 2'b10, 16'h7777, 0, 0); we3 = 1; cs3 = 1;
        tick(); we3 = 0; cs3 = 0;
        chk("n3_seed", amp3, 48'h7777);
        chk("n3_err_idle", err3, 0);
        sel3 = 2'd3; cmd = mk_cmd(2'b10, 24'h123456, 0, 0, 0, 0, 2'b10, 16'h1111, 1, 4'h5);
        we3 = 1; cs3 = 1;
        tick(); we3 = 0; cs3 = 0;
        chk("n3_err",   err3, 1);
        chk("n3_cso",   cso3, 0);
        chk("n3_amp",   amp3, 48'h7777);
        chk("n3_env",   env3, 0);
        chk("n3_dirty", dty3, 0);
        tick();
        chk("n3_err_1cyc", err3, 0);
        sel3 = 2'd0; cs3 = 1;
        tick(); cs3 = 0;
        chk("n3_stage_intact", amp3, 48'h7777);
        chk("n3_cfg_intact",   cfg3, 0);
        chk("n4_err_never",    err4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
